// File: rtl/xst_pkg.sv
// Shared widths, types and the bit-clock helper for the xst serial transmit shifter.
package xst_pkg;
   localparam int unsigned FRAME_W = 64;
   localparam int unsigned CNT_W   = 6;
   localparam int unsigned BRG_W   = 16;

   typedef logic [FRAME_W-1:0] frame_t;
   typedef logic [CNT_W-1:0]   cnt_t;
   typedef logic [BRG_W-1:0]   brg_t;

   // Bit clock is high during the first half of each cell and parks high when idle.
   function automatic logic bit_clock(logic idle, brg_t brg, brg_t baud);
      return idle | (brg >= (baud >> 1));
   endfunction
endpackage

// File: rtl/xst_if.sv
// Host/pin bundle of the xst transmitter: frame load controls in, serial pin and status out.
interface xst_if;
   xst_pkg::frame_t dat_i;
   xst_pkg::cnt_t   bits_i;
   logic            txreg_we_i;
   logic            txreg_oe_i;
   xst_pkg::brg_t   txbaud_i;
   logic            rxd_i;
   logic            txd_o;
   logic            txc_o;
   logic            idle_o;
   xst_pkg::brg_t   brg_o;

   modport master (
      output dat_i, bits_i, txreg_we_i, txreg_oe_i, txbaud_i, rxd_i,
      input  txd_o, txc_o, idle_o, brg_o
   );

   modport slave (
      input  dat_i, bits_i, txreg_we_i, txreg_oe_i, txbaud_i, rxd_i,
      output txd_o, txc_o, idle_o, brg_o
   );
endinterface

// File: rtl/xst_brg.sv
// Baud down-counter: loads and latches the divisor, counts each cell down to zero, reloads between cells.
module xst_brg
   import xst_pkg::*;
(
   input  logic clk_i,
   input  logic reset_i,
   input  logic load_i,
   input  brg_t load_val_i,
   input  logic busy_i,
   input  logic last_i,
   output brg_t brg_o,
   output brg_t baud_o,
   output logic zero_o
);
   brg_t brg_q, brg_d;
   brg_t baud_q, baud_d;

   always_comb begin
      brg_d  = brg_q;
      baud_d = baud_q;
      if (load_i) begin
         brg_d  = load_val_i;
         baud_d = load_val_i;
      end else if (busy_i) begin
         // On the final cell the counter stays at zero as the frame goes idle.
         if (brg_q != '0)  brg_d = brg_q - 1'b1;
         else if (!last_i) brg_d = baud_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         brg_q  <= '0;
         baud_q <= '0;
      end else begin
         brg_q  <= brg_d;
         baud_q <= baud_d;
      end
   end

   assign brg_o  = brg_q;
   assign baud_o = baud_q;
   assign zero_o = (brg_q == '0);
endmodule

// File: rtl/xst.sv
// Serial transmit shifter: shifts a preformatted 64-bit frame out LSB first, paced by xst_brg.
module xst
   import xst_pkg::*;
(
   input  logic clk_i,
   input  logic reset_i,
   xst_if.slave bus
);
   frame_t shreg_q, shreg_d;
   cnt_t   cnt_q, cnt_d;
   brg_t   brg, baud;
   logic   brg_zero;
   logic   busy;

   assign busy = (cnt_q != '0);

   xst_brg u_brg (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .load_i     (bus.txreg_we_i),
      .load_val_i (bus.txbaud_i),
      .busy_i     (busy),
      .last_i     (cnt_q == cnt_t'(1)),
      .brg_o      (brg),
      .baud_o     (baud),
      .zero_o     (brg_zero)
   );

   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      if (bus.txreg_we_i) begin
         shreg_d = bus.dat_i;
         cnt_d   = bus.bits_i;
      end else if (busy && brg_zero) begin
         shreg_d = {bus.rxd_i, shreg_q[FRAME_W-1:1]};
         cnt_d   = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         shreg_q <= '1;
         cnt_q   <= '0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.idle_o = ~busy;
   assign bus.txd_o  = bus.txreg_oe_i ? shreg_q[0] : 1'b1;
   assign bus.txc_o  = bit_clock(~busy, brg, baud);
   assign bus.brg_o  = brg;
endmodule

// File: tb/tb_xst.sv
// Self-checking bench for xst: per-cycle expectations derived from frame/bit-count/divisor rules.
module tb_xst;
   import xst_pkg::*;

   typedef struct packed {
      logic d;
      brg_t brg;
      logic txc;
      logic idle;
   } exp_t;

   logic   clk = 1'b0;
   logic   reset;
   xst_if  bus();
   exp_t   q[$];
   int     n_chk = 0;
   int     n_fail = 0;

   xst dut (.clk_i(clk), .reset_i(reset), .bus(bus));

   always #5 clk = ~clk;

   // Expected cycle-by-cycle view of a frame: each cell holds its data bit for baud+1 cycles
   // while the counter walks baud..0, then one idle cycle showing the next unsent frame bit.
   function automatic void build(frame_t dat, int unsigned bits, int unsigned baud);
      exp_t e;
      q.delete();
      for (int unsigned k = 0; k < bits; k++) begin
         for (int unsigned j = 0; j <= baud; j++) begin
            e.d    = dat[k];
            e.brg  = brg_t'(baud - j);
            e.txc  = ((baud - j) >= baud / 2);
            e.idle = 1'b0;
            q.push_back(e);
         end
      end
      e.d    = dat[bits];
      e.brg  = (bits == 0) ? brg_t'(baud) : '0;
      e.txc  = 1'b1;
      e.idle = 1'b1;
      q.push_back(e);
   endfunction

   task automatic start(frame_t dat, int unsigned bits, int unsigned baud);
      @(negedge clk);
      bus.dat_i      = dat;
      bus.bits_i     = cnt_t'(bits);
      bus.txbaud_i   = brg_t'(baud);
      bus.txreg_we_i = 1'b1;
      build(dat, bits, baud);
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_chk += 4;
      if (bus.idle_o !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b want 1", bus.idle_o); end
      if (bus.txd_o !== 1'b1)  begin n_fail++; $display("FAIL reset_txd got %b want 1", bus.txd_o); end
      if (bus.brg_o !== '0)    begin n_fail++; $display("FAIL reset_brg got %0d want 0", bus.brg_o); end
      if (bus.txc_o !== 1'b1)  begin n_fail++; $display("FAIL reset_txc got %b want 1", bus.txc_o); end
   endtask

   task automatic test_frame11(input logic oe, input string name);
      exp_t e;
      int   cyc = 0;
      logic want_txd;
      bus.txreg_oe_i = oe;
      bus.rxd_i      = 1'b1;
      start({53'h1F_FFFF_FFFF_FFFF, 11'b11_00010001_0}, 11, 4);
      while (q.size() > 0) begin
         @(negedge clk);
         bus.txreg_we_i = 1'b0;
         #1;
         e = q.pop_front();
         want_txd = oe ? e.d : 1'b1;
         n_chk++;
         if ({bus.txd_o, bus.brg_o, bus.txc_o, bus.idle_o} !== {want_txd, e.brg, e.txc, e.idle}) begin
            n_fail++;
            $display("FAIL %s cyc %0d got txd=%b brg=%0d txc=%b idle=%b want txd=%b brg=%0d txc=%b idle=%b",
                     name, cyc, bus.txd_o, bus.brg_o, bus.txc_o, bus.idle_o, want_txd, e.brg, e.txc, e.idle);
         end
         cyc++;
      end
   endtask

   task automatic test_baud0();
      exp_t   e;
      int     cyc = 0;
      frame_t d;
      d = {$urandom, $urandom};
      d[2:0] = 3'b101;
      bus.txreg_oe_i = 1'b1;
      start(d, 3, 0);
      while (q.size() > 0) begin
         @(negedge clk);
         bus.txreg_we_i = 1'b0;
         #1;
         e = q.pop_front();
         n_chk++;
         if ({bus.txd_o, bus.brg_o, bus.txc_o, bus.idle_o} !== {e.d, e.brg, e.txc, e.idle}) begin
            n_fail++;
            $display("FAIL baud0 cyc %0d got txd=%b brg=%0d txc=%b idle=%b want txd=%b brg=%0d txc=%b idle=%b",
                     cyc, bus.txd_o, bus.brg_o, bus.txc_o, bus.idle_o, e.d, e.brg, e.txc, e.idle);
         end
         cyc++;
      end
   endtask

   task automatic test_midframe_write();
      exp_t   e;
      int     cyc = 0;
      frame_t d;
      bus.txreg_oe_i = 1'b1;
      start({$urandom, $urandom}, 10, 3);
      repeat (2 * 4) begin
         @(negedge clk);
         bus.txreg_we_i = 1'b0;
         #1;
         e = q.pop_front();
         n_chk++;
         if ({bus.txd_o, bus.brg_o, bus.idle_o} !== {e.d, e.brg, e.idle}) begin
            n_fail++;
            $display("FAIL midwr_old cyc %0d got txd=%b brg=%0d idle=%b want txd=%b brg=%0d idle=%b",
                     cyc, bus.txd_o, bus.brg_o, bus.idle_o, e.d, e.brg, e.idle);
         end
         cyc++;
      end
      d = {$urandom, $urandom};
      d[0] = 1'b0;
      start(d, 7, 5);
      while (q.size() > 0) begin
         @(negedge clk);
         bus.txreg_we_i = 1'b0;
         #1;
         e = q.pop_front();
         n_chk++;
         if ({bus.txd_o, bus.brg_o, bus.txc_o, bus.idle_o} !== {e.d, e.brg, e.txc, e.idle}) begin
            n_fail++;
            $display("FAIL midwr_new cyc %0d got txd=%b brg=%0d txc=%b idle=%b want txd=%b brg=%0d txc=%b idle=%b",
                     cyc, bus.txd_o, bus.brg_o, bus.txc_o, bus.idle_o, e.d, e.brg, e.txc, e.idle);
         end
         cyc++;
      end
   endtask

   task automatic test_random();
      exp_t e;
      int   cyc;
      logic want_txd;
      for (int f = 0; f < 10; f++) begin
         cyc = 0;
         start({$urandom, $urandom}, $urandom_range(16, 1), $urandom_range(5, 0));
         while (q.size() > 0) begin
            @(negedge clk);
            bus.txreg_we_i = 1'b0;
            bus.txreg_oe_i = 1'($urandom);
            bus.rxd_i      = 1'($urandom);
            bus.txbaud_i   = brg_t'($urandom);
            #1;
            e = q.pop_front();
            want_txd = bus.txreg_oe_i ? e.d : 1'b1;
            n_chk++;
            if ({bus.txd_o, bus.brg_o, bus.txc_o, bus.idle_o} !== {want_txd, e.brg, e.txc, e.idle}) begin
               n_fail++;
               $display("FAIL rand f%0d cyc %0d got txd=%b brg=%0d txc=%b idle=%b want txd=%b brg=%0d txc=%b idle=%b",
                        f, cyc, bus.txd_o, bus.brg_o, bus.txc_o, bus.idle_o, want_txd, e.brg, e.txc, e.idle);
            end
            cyc++;
         end
      end
   endtask

   task automatic test_reset_mid_and_bits0();
      exp_t   e;
      frame_t d;
      bus.txreg_oe_i = 1'b1;
      start({$urandom, $urandom}, 12, 6);
      repeat (9) begin
         @(negedge clk);
         bus.txreg_we_i = 1'b0;
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_chk++;
      if ({bus.idle_o, bus.txd_o, bus.brg_o, bus.txc_o} !== {1'b1, 1'b1, 16'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_mid got idle=%b txd=%b brg=%0d txc=%b want idle=1 txd=1 brg=0 txc=1",
                  bus.idle_o, bus.txd_o, bus.brg_o, bus.txc_o);
      end
      d = {$urandom, $urandom};
      start(d, 0, 9);
      @(negedge clk);
      bus.txreg_we_i = 1'b0;
      #1;
      e = q.pop_front();
      n_chk++;
      if ({bus.idle_o, bus.txd_o, bus.brg_o, bus.txc_o} !== {e.idle, e.d, e.brg, e.txc}) begin
         n_fail++;
         $display("FAIL bits0 got idle=%b txd=%b brg=%0d txc=%b want idle=%b txd=%b brg=%0d txc=%b",
                  bus.idle_o, bus.txd_o, bus.brg_o, bus.txc_o, e.idle, e.d, e.brg, e.txc);
      end
      repeat (3) @(negedge clk);
      #1;
      n_chk++;
      if ({bus.idle_o, bus.brg_o} !== {1'b1, e.brg}) begin
         n_fail++;
         $display("FAIL bits0_hold got idle=%b brg=%0d want idle=1 brg=%0d", bus.idle_o, bus.brg_o, e.brg);
      end
   endtask

   initial begin
      reset          = 1'b1;
      bus.dat_i      = '0;
      bus.bits_i     = '0;
      bus.txreg_we_i = 1'b0;
      bus.txreg_oe_i = 1'b1;
      bus.txbaud_i   = '0;
      bus.rxd_i      = 1'b1;
      test_reset();
      test_frame11(1'b1, "frame11");
      test_frame11(1'b0, "frame11_oe0");
      test_baud0();
      test_midframe_write();
      test_random();
      test_reset_mid_and_bits0();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
